joystick_conditioner: RTL and testbench

//  Parametrised successor to the fixed 4-axis joystick front end. Takes an ADC sample stream
//  (channel-tagged), applies per-axis IIR smoothing, runtime centre calibration, deadzone, and

---
 rtl/joystick_conditioner.sv | 204 ++++++++++++++++++++
 tb/tb_joystick_conditioner.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_conditioner.sv
// Joystick front end: IIR smoothing, centre calibration, deadzone and saturating scale per axis,
// plus debounced buttons. Optional macro JOY_AXIS_INVERT_EN adds per-axis output inversion.
module joystick_conditioner #(
  parameter int N_AXES    = 4,
  parameter int ADC_W     = 12,
  parameter int OUT_W     = 11,
  parameter int OUT_MID   = 320,
  parameter int SCALE_NUM = 5,
  parameter int SCALE_SH  = 5,
  parameter int DEADZONE  = 64,
  parameter int FILT_SH   = 2,
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = 100000,
  parameter int CNT_W     = 2,
  localparam int CH_W     = (N_AXES > 1) ? $clog2(N_AXES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  input  logic [CH_W-1:0]           s_ch,
  input  logic [ADC_W-1:0]          s_data,
  input  logic                      cal_req,
  output logic                      cal_done,
  output logic [N_AXES*OUT_W-1:0]   axis_pos,
  output logic [N_AXES-1:0]         axis_upd,
`ifdef JOY_AXIS_INVERT_EN
  input  logic [N_AXES-1:0]         axis_inv,
`endif
  input  logic [N_BTN-1:0]          btn_in,
  output logic [N_BTN-1:0]          btn_level,
  output logic [N_BTN-1:0]          btn_press,
  output logic [N_BTN*CNT_W-1:0]    btn_cnt
);
  localparam int FW  = ADC_W + 1;
  localparam int PW  = ADC_W + 40;
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic signed [FW-1:0] DZ_P = FW'(DEADZONE);
  localparam logic signed [FW-1:0] DZ_N = FW'(-DEADZONE);
  localparam logic signed [PW-1:0] VMAX = PW'((1 << OUT_W) - 1);

  typedef enum logic {RUN, CAL} state_e;

  function automatic logic [ADC_W-1:0] filt_step(input logic [ADC_W-1:0] f,
                                                 input logic [ADC_W-1:0] s);
    logic signed [FW-1:0] diff;
    diff = $signed({1'b0, s}) - $signed({1'b0, f});
    diff = diff >>> FILT_SH;
    return ADC_W'($signed({1'b0, f}) + diff);
  endfunction

  function automatic logic signed [FW-1:0] deadzone(input logic signed [FW-1:0] d);
    return (d <= DZ_P && d >= DZ_N) ? '0 : d;
  endfunction

  function automatic logic [OUT_W-1:0] sat_out(input logic signed [FW-1:0] d);
    logic signed [PW-1:0] v;
    v = PW'(OUT_MID) + ((PW'(d) * PW'(SCALE_NUM)) >>> SCALE_SH);
    if (v[PW-1])   return '0;
    if (v > VMAX)  return '1;
    return v[OUT_W-1:0];
  endfunction

  state_e                   state_q, state_d;
  logic [N_AXES-1:0]        seen_q, seen_d, primed_q;
  logic                     cal_done_q, cal_done_d;
  logic [ADC_W-1:0]         filt_q   [N_AXES];
  logic [ADC_W-1:0]         centre_q [N_AXES];
  logic                     ch_ok, run_acc, cal_acc;
  logic [ADC_W-1:0]         filt_new;

  if ((1 << CH_W) == N_AXES) begin : g_full_ch
    assign ch_ok = 1'b1;
  end else begin : g_part_ch
    assign ch_ok = (s_ch < CH_W'(N_AXES));
  end

  assign run_acc  = s_valid && ch_ok && (state_q == RUN);
  assign cal_acc  = s_valid && ch_ok && (state_q == CAL) && !seen_q[s_ch];
  assign filt_new = primed_q[s_ch] ? filt_step(filt_q[s_ch], s_data) : s_data;

  always_comb begin
    state_d    = state_q;
    seen_d     = seen_q;
    cal_done_d = 1'b0;
    case (state_q)
      RUN: if (cal_req) state_d = CAL;
      CAL: begin
        if (cal_acc) seen_d[s_ch] = 1'b1;
        if (&seen_d) begin
          cal_done_d = 1'b1;
          seen_d     = '0;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      seen_q     <= '0;
      cal_done_q <= 1'b0;
      primed_q   <= '0;
      for (int k = 0; k < N_AXES; k++) centre_q[k] <= {1'b1, {(ADC_W-1){1'b0}}};
    end else begin
      state_q    <= state_d;
      seen_q     <= seen_d;
      cal_done_q <= cal_done_d;
      if (run_acc || cal_acc) primed_q[s_ch] <= 1'b1;
      if (cal_acc) centre_q[s_ch] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (run_acc)      filt_q[s_ch] <= filt_new;
    else if (cal_acc) filt_q[s_ch] <= s_data;
  end

  // Stage 1: filtered sample
  logic                     vld_p0, vld_p1;
  logic [ADC_W-1:0]         filt_p0;
  logic [CH_W-1:0]          ch_p0, ch_p1;
  logic signed [FW-1:0]     d_p1;

  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= run_acc;
    filt_p0 <= filt_new;
    ch_p0   <= s_ch;
  end

  // Stage 2: centre subtraction and deadzone
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
    d_p1  <= deadzone($signed({1'b0, filt_p0}) - $signed({1'b0, centre_q[ch_p0]}));
    ch_p1 <= ch_p0;
  end

  // Stage 3: scale, saturate, optional inversion
  logic [OUT_W-1:0]         pos_p2;
  logic [N_AXES*OUT_W-1:0]  axis_pos_q;
  logic [N_AXES-1:0]        axis_upd_q;

  always_comb begin
    pos_p2 = sat_out(d_p1);
`ifdef JOY_AXIS_INVERT_EN
    if (axis_inv[ch_p1]) pos_p2 = ~pos_p2;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      axis_pos_q <= {N_AXES{OUT_W'(OUT_MID)}};
      axis_upd_q <= '0;
    end else begin
      axis_upd_q <= vld_p1 ? (N_AXES'(1) << ch_p1) : '0;
      if (vld_p1) axis_pos_q[ch_p1*OUT_W +: OUT_W] <= pos_p2;
    end
  end

  assign axis_pos = axis_pos_q;
  assign axis_upd = axis_upd_q;
  assign cal_done = cal_done_q;

  logic [N_BTN-1:0]         sync1_q, sync2_q, level_q, level_dly_q, press_q;
  logic [DBW-1:0]           db_q [N_BTN];
  logic [N_BTN*CNT_W-1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      press_q     <= '0;
      cnt_q       <= '0;
      for (int b = 0; b < N_BTN; b++) db_q[b] <= '0;
    end else begin
      sync1_q     <= btn_in;
      sync2_q     <= sync1_q;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      for (int b = 0; b < N_BTN; b++) begin
        // any agreement restarts the stability count
        if (sync2_q[b] == level_q[b]) begin
          db_q[b] <= '0;
        end else if (db_q[b] == DBW'(DB_CYCLES - 1)) begin
          db_q[b]    <= '0;
          level_q[b] <= sync2_q[b];
        end else begin
          db_q[b] <= db_q[b] + 1'b1;
        end
        cnt_q[b*CNT_W +: CNT_W] <= cnt_q[b*CNT_W +: CNT_W] + CNT_W'(press_q[b]);
      end
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;
  assign btn_cnt   = cnt_q;

endmodule

// File: tb/tb_joystick_conditioner.sv
// Directed bench for joystick_conditioner: four parameterisations share one input stream.
module tb_joystick_conditioner;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic [1:0]  s_ch = '0;
  logic [11:0] s_data = '0;
  logic        cal_req = 1'b0;
  logic [3:0]  btn_in = '0;

  logic        cd0, cd1, cd2, cd3;
  logic [43:0] pos0, pos1, pos2;
  logic [32:0] pos3;
  logic [3:0]  upd0, upd1, upd2;
  logic [2:0]  upd3;
  logic [3:0]  lvl0, lvl1, lvl2, lvl3, prs0, prs1, prs2, prs3;
  logic [7:0]  cnt0, cnt1, cnt2, cnt3;

  int n_checks = 0;
  int n_errors = 0;
  int presses  = 0;
  int n_cd, n_upd;

  always #5 clk = ~clk;

  joystick_conditioner #(.FILT_SH(0), .DB_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ch(s_ch), .s_data(s_data),
    .cal_req(cal_req), .cal_done(cd0), .axis_pos(pos0), .axis_upd(upd0),
`ifdef JOY_AXIS_INVERT_EN
    .axis_inv(4'b0000),
`endif
    .btn_in(btn_in), .btn_level(lvl0), .btn_press(prs0), .btn_cnt(cnt0));

  joystick_conditioner #(.FILT_SH(2), .DB_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ch(s_ch), .s_data(s_data),
    .cal_req(cal_req), .cal_done(cd1), .axis_pos(pos1), .axis_upd(upd1),
`ifdef JOY_AXIS_INVERT_EN
    .axis_inv(4'b0000),
`endif
    .btn_in(btn_in), .btn_level(lvl1), .btn_press(prs1), .btn_cnt(cnt1));

  joystick_conditioner #(.FILT_SH(0), .SCALE_NUM(40), .DB_CYCLES(4)) dut2 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ch(s_ch), .s_data(s_data),
    .cal_req(cal_req), .cal_done(cd2), .axis_pos(pos2), .axis_upd(upd2),
`ifdef JOY_AXIS_INVERT_EN
    .axis_inv(4'b0000),
`endif
    .btn_in(btn_in), .btn_level(lvl2), .btn_press(prs2), .btn_cnt(cnt2));

  joystick_conditioner #(.N_AXES(3), .FILT_SH(0), .DB_CYCLES(4)) dut3 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ch(s_ch), .s_data(s_data),
    .cal_req(cal_req), .cal_done(cd3), .axis_pos(pos3), .axis_upd(upd3),
`ifdef JOY_AXIS_INVERT_EN
    .axis_inv(3'b000),
`endif
    .btn_in(btn_in), .btn_level(lvl3), .btn_press(prs3), .btn_cnt(cnt3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Sample taken at the following posedge; returns at the negedge after it.
  task automatic send(input logic [1:0] ch, input logic [11:0] d);
    @(negedge clk);
    s_valid = 1'b1;
    s_ch    = ch;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_cal();
    @(negedge clk);
    cal_req = 1'b1;
    @(negedge clk);
    cal_req = 1'b0;
  endtask

  task automatic run_btn(input logic lvl, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      btn_in[0] = lvl;
      if (prs0[0]) presses++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_pos", 32'(pos0 == {4{11'd320}}), 32'd1);
    check("rst_upd", 32'(upd0), 32'd0);
    check("rst_cal_done", 32'(cd0), 32'd0);
    check("rst_btn_level", 32'(lvl0), 32'd0);
    check("rst_btn_cnt", 32'(cnt0), 32'd0);

    // scaling, latency and filter
    send(2'd1, 12'd2048);
    repeat (2) @(negedge clk);
    check("filt_first", 32'(pos1[11 +: 11]), 32'd320);
    send(2'd1, 12'd4095);
    repeat (2) @(negedge clk);
    check("filt_step", 32'(pos1[11 +: 11]), 32'd399);

    send(2'd0, 12'd4095);
    @(negedge clk);
    check("lat_t2_upd", 32'(upd0), 32'd0);
    @(negedge clk);
    check("lat_t3_upd", 32'(upd0), 32'd1);
    check("scale_max", 32'(pos0[0 +: 11]), 32'd639);
    @(negedge clk);
    check("upd_one_cycle", 32'(upd0), 32'd0);
    send(2'd0, 12'd0);
    repeat (2) @(negedge clk);
    check("scale_min", 32'(pos0[0 +: 11]), 32'd0);
    send(2'd0, 12'd2100);
    repeat (2) @(negedge clk);
    check("scale_deadzone", 32'(pos0[0 +: 11]), 32'd320);

    send(2'd2, 12'd4095);
    repeat (2) @(negedge clk);
    check("sat_high", 32'(pos2[22 +: 11]), 32'd2047);
    send(2'd2, 12'd0);
    repeat (2) @(negedge clk);
    check("sat_low", 32'(pos2[22 +: 11]), 32'd0);

    // out-of-range channel on the 3-axis instance
    do_reset();
    n_upd = 0;
    send(2'd3, 12'd4095);
    repeat (4) begin
      @(negedge clk);
      if (|upd3) n_upd++;
    end
    check("drop_upd", 32'(n_upd), 32'd0);
    check("drop_pos", 32'(pos3 == {3{11'd320}}), 32'd1);

    // calibration
    do_reset();
    pulse_cal();
    n_cd = 0;
    n_upd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cd0) n_cd++;
      if (|upd0) n_upd++;
      if (i < 4) begin
        s_valid = 1'b1;
        s_ch    = 2'(i);
        s_data  = 12'd2148;
      end else begin
        s_valid = 1'b0;
      end
    end
    check("cal_done_pulses", 32'(n_cd), 32'd1);
    check("cal_no_upd", 32'(n_upd), 32'd0);
    send(2'd0, 12'd2148);
    repeat (2) @(negedge clk);
    check("cal_centre", 32'(pos0[0 +: 11]), 32'd320);
    send(2'd0, 12'd4095);
    repeat (2) @(negedge clk);
    check("cal_max", 32'(pos0[0 +: 11]), 32'd624);

    // reset in the middle of calibration
    do_reset();
    pulse_cal();
    send(2'd0, 12'd2148);
    send(2'd1, 12'd2148);
    do_reset();
    n_cd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cd0) n_cd++;
      if (i < 2) begin
        s_valid = 1'b1;
        s_ch    = 2'(i + 2);
        s_data  = 12'd2148;
      end else begin
        s_valid = 1'b0;
      end
    end
    check("rstcal_no_done", 32'(n_cd), 32'd0);
    send(2'd0, 12'd4095);
    repeat (2) @(negedge clk);
    check("rstcal_default_centre", 32'(pos0[0 +: 11]), 32'd639);

    // buttons
    do_reset();
    presses = 0;
    run_btn(1'b1, 3);
    run_btn(1'b0, 12);
    check("glitch_press", 32'(presses), 32'd0);
    check("glitch_level", 32'(lvl0[0]), 32'd0);
    run_btn(1'b1, 10);
    check("hold_level", 32'(lvl0[0]), 32'd1);
    run_btn(1'b0, 10);
    check("hold_press", 32'(presses), 32'd1);
    check("hold_cnt", 32'(cnt0[1:0]), 32'd1);
    check("release_level", 32'(lvl0[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      run_btn(1'b1, 10);
      run_btn(1'b0, 10);
    end
    check("wrap_press", 32'(presses), 32'd5);
    check("wrap_cnt", 32'(cnt0[1:0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
